// File: rtl/gate_sweep_checker.sv
// Exhaustive N-input gate sweeper with golden-function self-check.
// Walks every vector, samples after SETTLE cycles, records errors.
module gate_sweep_checker #(
  parameter int N      = 2,
  parameter int SETTLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   mode,
  input  logic         dut_f,
  output logic [N-1:0] stim,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail_vec,
  output logic         first_fail_valid
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N-1:0]  STIM_ONE = N'(1);
  localparam logic [N:0]    ERR_ONE  = (N+1)'(1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     mode_q, mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   stim_d;
  logic           busy_d, done_d, pass_d;
  logic [N:0]     err_d;
  logic [N-1:0]   ffvec_d;
  logic           ffv_d;
  logic           expected;
  logic           mismatch;
  logic           last_vec;

  // Golden response of the selected gate for the current vector
  always_comb begin
    expected = 1'b0;
    unique case (mode_q)
      3'd0: expected = ~|stim;
      3'd1: expected = |stim;
      3'd2: expected = ~&stim;
      3'd3: expected = &stim;
      3'd4: expected = ^stim;
      3'd5: expected = ~^stim;
      3'd6: expected = ~stim[0];
      3'd7: expected = stim[0];
    endcase
  end

  assign mismatch = (dut_f != expected);
  assign last_vec = &stim;

  // Next-state and next-output logic for the sweep FSM
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    stim_d  = stim;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    err_d   = err_count;
    ffv_d   = first_fail_valid;
    ffvec_d = first_fail_vec;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          stim_d  = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          mode_d  = mode;
          cnt_d   = CNT_LOAD;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          if (mismatch) begin
            err_d = err_count + ERR_ONE;
            if (!first_fail_valid) begin
              ffv_d   = 1'b1;
              ffvec_d = stim;
            end
          end
          if (last_vec) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stim_d  = '0;
            pass_d  = (err_d == '0);
          end else begin
            stim_d = stim + STIM_ONE;
            cnt_d  = CNT_LOAD;
          end
        end
      end
    endcase
  end

  // State and result registers, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      mode_q           <= '0;
      cnt_q            <= '0;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      cnt_q            <= cnt_d;
      stim             <= stim_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      err_count        <= err_d;
      first_fail_valid <= ffv_d;
      first_fail_vec   <= ffvec_d;
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: four parameterisations, modelled
// gates, expected sweep results queued and checked at done.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         err;
    logic       ffv;
    logic [7:0] ffvec;
    logic       pass;
    int         cycles;
  } exp_t;

  exp_t sbq [$];
  int n_chk = 0;
  int n_fail = 0;

  int nw [4] = '{2, 3, 2, 2};
  int st [4] = '{4, 2, 2, 1};

  logic [3:0] start = '0;
  logic [2:0] mode [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
  int         kind [4] = '{0, 0, 0, 0};
  logic [3:0] dut_f;
  logic [2:0] pipe [4];

  logic [7:0] o_stim [4];
  logic [8:0] o_err [4];
  logic [7:0] o_ffvec [4];
  logic [3:0] o_busy, o_done, o_pass, o_ffv;

  logic [1:0] stim_a, ffvec_a, stim_c, ffvec_c, stim_d, ffvec_d;
  logic [2:0] stim_b, ffvec_b, err_a, err_c, err_d;
  logic [3:0] err_b;

  gate_sweep_checker #(.N(2), .SETTLE(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]),
    .dut_f(dut_f[0]), .stim(stim_a), .busy(o_busy[0]),
    .done(o_done[0]), .pass(o_pass[0]), .err_count(err_a),
    .first_fail_vec(ffvec_a), .first_fail_valid(o_ffv[0]));

  gate_sweep_checker #(.N(3), .SETTLE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]),
    .dut_f(dut_f[1]), .stim(stim_b), .busy(o_busy[1]),
    .done(o_done[1]), .pass(o_pass[1]), .err_count(err_b),
    .first_fail_vec(ffvec_b), .first_fail_valid(o_ffv[1]));

  gate_sweep_checker #(.N(2), .SETTLE(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode[2]),
    .dut_f(dut_f[2]), .stim(stim_c), .busy(o_busy[2]),
    .done(o_done[2]), .pass(o_pass[2]), .err_count(err_c),
    .first_fail_vec(ffvec_c), .first_fail_valid(o_ffv[2]));

  gate_sweep_checker #(.N(2), .SETTLE(1)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .mode(mode[3]),
    .dut_f(dut_f[3]), .stim(stim_d), .busy(o_busy[3]),
    .done(o_done[3]), .pass(o_pass[3]), .err_count(err_d),
    .first_fail_vec(ffvec_d), .first_fail_valid(o_ffv[3]));

  assign o_stim[0]  = 8'(stim_a);
  assign o_stim[1]  = 8'(stim_b);
  assign o_stim[2]  = 8'(stim_c);
  assign o_stim[3]  = 8'(stim_d);
  assign o_err[0]   = 9'(err_a);
  assign o_err[1]   = 9'(err_b);
  assign o_err[2]   = 9'(err_c);
  assign o_err[3]   = 9'(err_d);
  assign o_ffvec[0] = 8'(ffvec_a);
  assign o_ffvec[1] = 8'(ffvec_b);
  assign o_ffvec[2] = 8'(ffvec_c);
  assign o_ffvec[3] = 8'(ffvec_d);

  // gates under test: 0 NOR, 1 NAND, 2 stuck-0, 3 NOR via 3 flops
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      pipe[i] <= {pipe[i][1:0], (o_stim[i] == 8'd0)};

  always_comb begin
    dut_f = '0;
    for (int i = 0; i < 4; i++)
      case (kind[i])
        0: dut_f[i] = (o_stim[i] == 8'd0);
        1: dut_f[i] = ($countones(o_stim[i]) != nw[i]);
        3: dut_f[i] = pipe[i][2];
        default: dut_f[i] = 1'b0;
      endcase
  end

  // lag = how many vectors behind the gate output is at sample time
  function automatic exp_t model(int n, int s, logic [2:0] m,
                                 int k, int lag);
    exp_t e;
    int ones, src;
    logic g, o;
    e.err = 0; e.ffv = 1'b0; e.ffvec = '0;
    e.cycles = (1 << n) * s;
    for (int v = 0; v < (1 << n); v++) begin
      ones = $countones(v);
      src = (v - lag < 0) ? 0 : v - lag;
      case (m)
        3'd0: g = (ones == 0);
        3'd1: g = (ones != 0);
        3'd2: g = (ones != n);
        3'd3: g = (ones == n);
        3'd4: g = (ones % 2 == 1);
        3'd5: g = (ones % 2 == 0);
        3'd6: g = (v % 2 == 0);
        default: g = (v % 2 == 1);
      endcase
      case (k)
        0, 3: o = ($countones(src) == 0);
        1: o = (ones != n);
        default: o = 1'b0;
      endcase
      if (o !== g) begin
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffvec = 8'(v);
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic run_sweep(int i, logic [2:0] m, int k, int lag,
                           bit poke);
    exp_t e;
    int cyc;
    @(negedge clk);
    mode[i] = m;
    kind[i] = k;
    start[i] = 1'b1;
    sbq.push_back(model(nw[i], st[i], m, k, lag));
    @(posedge clk);
    #1 start[i] = 1'b0;
    n_chk++;
    if (o_busy[i] !== 1'b1 || o_stim[i] !== 8'd0 ||
        o_done[i] !== 1'b0 || o_err[i] !== 9'd0 ||
        o_ffv[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL start_state[%0d]: busy=%b stim=%0d done=%b err=%0d ffv=%b want 1 0 0 0 0",
               i, o_busy[i], o_stim[i], o_done[i], o_err[i], o_ffv[i]);
    end
    cyc = 0;
    if (poke) begin
      @(negedge clk);
      start[i] = 1'b1;
      mode[i] = ~m;
      @(posedge clk);
      #1 start[i] = 1'b0;
      cyc = 1;
    end
    while (o_done[i] !== 1'b1 && cyc < 1000) begin
      @(posedge clk);
      #1 cyc++;
    end
    mode[i] = m;
    e = sbq.pop_front();
    n_chk++;
    if (cyc != e.cycles) begin
      n_fail++;
      $display("FAIL sweep_len[%0d]: got %0d want %0d", i, cyc, e.cycles);
    end
    n_chk++;
    if (o_err[i] !== 9'(e.err)) begin
      n_fail++;
      $display("FAIL err_count[%0d]: got %0d want %0d", i, o_err[i], e.err);
    end
    n_chk++;
    if (o_ffv[i] !== e.ffv || o_ffvec[i] !== e.ffvec) begin
      n_fail++;
      $display("FAIL first_fail[%0d]: got %b/%0d want %b/%0d",
               i, o_ffv[i], o_ffvec[i], e.ffv, e.ffvec);
    end
    n_chk++;
    if (o_pass[i] !== e.pass || o_busy[i] !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_busy[%0d]: got pass=%b busy=%b want %b 0",
               i, o_pass[i], o_busy[i], e.pass);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({o_busy[i], o_done[i], o_pass[i], o_ffv[i]} !== 4'b0 ||
          o_stim[i] !== 8'd0 || o_err[i] !== 9'd0 ||
          o_ffvec[i] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: bdpv=%b%b%b%b stim=%0d err=%0d want all 0",
                 i, o_busy[i], o_done[i], o_pass[i], o_ffv[i],
                 o_stim[i], o_err[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nor_pass();
    run_sweep(0, 3'd0, 0, 0, 1'b0);
  endtask

  task automatic test_nand_fail();
    run_sweep(0, 3'd0, 1, 0, 1'b0);
  endtask

  task automatic test_xor_stuck();
    run_sweep(1, 3'd4, 2, 0, 1'b0);
  endtask

  task automatic test_modes();
    run_sweep(1, 3'd1, 2, 0, 1'b0);
    run_sweep(1, 3'd3, 1, 0, 1'b0);
    run_sweep(1, 3'd5, 0, 0, 1'b0);
    run_sweep(1, 3'd6, 2, 0, 1'b0);
    run_sweep(1, 3'd7, 2, 0, 1'b0);
  endtask

  task automatic test_pipeline();
    run_sweep(0, 3'd0, 3, 0, 1'b0);
    run_sweep(2, 3'd0, 3, 1, 1'b0);
  endtask

  task automatic test_mid_reset();
    int cyc;
    @(negedge clk);
    mode[0] = 3'd0;
    kind[0] = 1;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    cyc = 0;
    while (o_stim[0] !== 8'd2 && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    n_chk++;
    if (o_stim[0] !== 8'd2 || o_err[0] !== 9'd1) begin
      n_fail++;
      $display("FAIL mid_sweep: stim=%0d err=%0d want 2 1",
               o_stim[0], o_err[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({o_busy[0], o_done[0], o_pass[0], o_ffv[0]} !== 4'b0 ||
        o_stim[0] !== 8'd0 || o_err[0] !== 9'd0 ||
        o_ffvec[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b stim=%0d err=%0d ffv=%b want 0",
               o_busy[0], o_stim[0], o_err[0], o_ffv[0]);
    end
    #3 rst_n = 1'b1;
    run_sweep(0, 3'd0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sweep(3, 3'd0, 1, 0, 1'b1);
    run_sweep(3, 3'd0, 1, 0, 1'b0);
    run_sweep(3, 3'd2, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nor_pass();
    test_nand_fail();
    test_xor_stuck();
    test_modes();
    test_pipeline();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
